fp_round_pack: RTL and testbench

FP_ROUND_PACK -- requirements
Module: fp_round_pack

---
 rtl/fp_round_pack.sv | 146 ++++++++++++++
 tb/tb_fp_round_pack.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_round_pack.sv
// Purpose : round a normalized {hidden, fraction, G, R, S} mantissa and pack an IEEE-style result with flags.
// Latency : 2 cycles (S1 round, S2 post-normalize + pack), 1 beat/cycle when out_ready is high.
// Backpr. : valid/ready; a stalled S2 holds its result, S1 fills behind it, then in_ready drops.
// Ports   : clk, rst (sync, active-high); in_valid/in_ready + in_sign/in_exp/in_mant/in_nan/in_inf/rmode;
//           out_valid/out_ready + out_result {sign, exp, fraction} and out_flags {overflow, underflow, inexact, nan}.
module fp_round_pack #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_sign,
  input  logic [EXP_W+1:0]         in_exp,
  input  logic [MAN_W+3:0]         in_mant,
  input  logic                     in_nan,
  input  logic                     in_inf,
  input  logic [1:0]               rmode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     out_result,
  output logic [3:0]               out_flags
);

  localparam int XE_W = EXP_W + 3;  // one extra bit so exponent + carry never wraps
  localparam logic signed [XE_W-1:0] EXP_MAX  = {3'b000, {EXP_W{1'b1}}};
  localparam logic signed [XE_W-1:0] EXP_ZERO = '0;
  localparam logic [EXP_W-1:0]       EXP_BIG  = {{(EXP_W-1){1'b1}}, 1'b0};

  localparam logic [1:0] RM_RNE = 2'b00;
  localparam logic [1:0] RM_RTZ = 2'b01;
  localparam logic [1:0] RM_RDN = 2'b10;
  localparam logic [1:0] RM_RUP = 2'b11;

  // Handshake
  logic s1_valid_q, s2_valid_q;
  logic s1_adv, s2_adv;

  assign s2_adv    = !s2_valid_q || out_ready;
  assign s1_adv    = !s1_valid_q || s2_adv;
  assign in_ready  = s1_adv && !rst;
  assign out_valid = s2_valid_q && !rst;

  // S1: rounding increment
  logic             rnd_lsb, rnd_g, rnd_r, rnd_s, inc;
  logic [MAN_W+1:0] mant_r_d;

  assign rnd_lsb = in_mant[3];
  assign rnd_g   = in_mant[2];
  assign rnd_r   = in_mant[1];
  assign rnd_s   = in_mant[0];

  always_comb begin
    inc = 1'b0;
    case (rmode)
      RM_RNE:  inc = rnd_g & (rnd_r | rnd_s | rnd_lsb);
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = in_sign & (rnd_g | rnd_r | rnd_s);
      default: inc = !in_sign & (rnd_g | rnd_r | rnd_s);
    endcase
  end

  assign mant_r_d = {1'b0, in_mant[MAN_W+3:3]} + {{(MAN_W+1){1'b0}}, inc};

  logic             s1_sign_q, s1_nan_q, s1_inf_q, s1_zero_q, s1_inexact_q;
  logic [EXP_W+1:0] s1_exp_q;
  logic [MAN_W+1:0] s1_mant_q;
  logic [1:0]       s1_rmode_q;

  // S2: post-normalize and classify
  logic                    carry, to_inf;
  logic signed [XE_W-1:0]  exp_n;
  logic [MAN_W-1:0]        frac_n;
  logic [EXP_W+MAN_W:0]    res_d, res_q;
  logic [3:0]              flags_d, flags_q;

  assign carry  = s1_mant_q[MAN_W+1];
  assign exp_n  = {s1_exp_q[EXP_W+1], s1_exp_q} + XE_W'(carry);
  assign frac_n = carry ? s1_mant_q[MAN_W:1] : s1_mant_q[MAN_W-1:0];

  // Overflow goes to infinity only when the rounding direction points away from zero.
  assign to_inf = (s1_rmode_q == RM_RNE) ||
                  ((s1_rmode_q == RM_RUP) && !s1_sign_q) ||
                  ((s1_rmode_q == RM_RDN) && s1_sign_q);

  always_comb begin
    res_d   = {s1_sign_q, exp_n[EXP_W-1:0], frac_n};
    flags_d = {2'b00, s1_inexact_q, 1'b0};
    if (s1_nan_q) begin
      res_d   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      flags_d = 4'b0001;
    end else if (s1_inf_q) begin
      res_d   = {s1_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags_d = 4'b0000;
    end else if (s1_zero_q) begin
      res_d   = {s1_sign_q, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
      flags_d = 4'b0000;
    end else if (exp_n >= EXP_MAX) begin
      res_d   = to_inf ? {s1_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                       : {s1_sign_q, EXP_BIG, {MAN_W{1'b1}}};
      flags_d = 4'b1010;
    end else if (exp_n <= EXP_ZERO) begin
      // No subnormal support: anything below the normal range flushes to signed zero.
      res_d   = {s1_sign_q, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
      flags_d = 4'b0110;
    end
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      res_q      <= '0;
      flags_q    <= '0;
    end else begin
      if (s1_adv) s1_valid_q <= in_valid;
      if (s2_adv) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          res_q   <= res_d;
          flags_q <= flags_d;
        end
      end
    end
  end

  // S1 datapath registers load only on an accepted beat.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      s1_sign_q    <= in_sign;
      s1_exp_q     <= in_exp;
      s1_mant_q    <= mant_r_d;
      s1_rmode_q   <= rmode;
      s1_nan_q     <= in_nan;
      s1_inf_q     <= in_inf;
      s1_zero_q    <= (in_mant == '0);
      s1_inexact_q <= rnd_g | rnd_r | rnd_s;
    end
  end

  assign out_result = res_q;
  assign out_flags  = flags_q;

endmodule

// File: tb/tb_fp_round_pack.sv
module tb_fp_round_pack;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [9:0]  in_exp;
  logic [26:0] in_mant;
  logic        in_nan;
  logic        in_inf;
  logic [1:0]  rmode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_flags;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        sign;
    logic [9:0]  exp;
    logic [26:0] mant;
    logic        nan;
    logic        inf;
    logic [1:0]  rm;
    logic [31:0] res;
    logic [3:0]  flg;
  } beat_t;

  logic [35:0] sb_q[$];

  fp_round_pack #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
    .in_nan(in_nan), .in_inf(in_inf), .rmode(rmode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  function automatic beat_t mk(logic s, logic [9:0] e, logic [22:0] f, logic [2:0] grs,
                               logic nan, logic inf, logic [1:0] rm,
                               logic [31:0] res, logic [3:0] flg);
    beat_t b;
    b.sign = s; b.exp = e; b.mant = {1'b1, f, grs};
    b.nan = nan; b.inf = inf; b.rm = rm; b.res = res; b.flg = flg;
    return b;
  endfunction

  // Drive one beat starting at posedge+1; acceptance is judged at the negedge before the edge.
  task automatic send(input beat_t b);
    int  budget = 0;
    bit  done = 0;
    in_valid = 1'b1; in_sign = b.sign; in_exp = b.exp; in_mant = b.mant;
    in_nan = b.nan; in_inf = b.inf; rmode = b.rm;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        sb_q.push_back({b.res, b.flg});
        done = 1;
      end else begin
        budget++;
        if (budget > 60) begin
          checks++; errors++;
          $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", budget);
          done = 1;
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_mant = '0;
    in_nan = 1'b0; in_inf = 1'b0; rmode = 2'b00; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b required 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
    checks++; if (out_result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h required 00000000", out_result); end
    checks++; if (out_flags !== 4'h0) begin errors++; $display("FAIL reset_flags: got %b required 0000", out_flags); end
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b required 1", in_ready); end
  endtask

  task automatic test_latency();
    logic [35:0] e;
    @(posedge clk); #1;
    in_valid = 1'b1; in_sign = 1'b0; in_exp = 10'd127; in_mant = {1'b1, 23'h400000, 3'b000};
    in_nan = 1'b0; in_inf = 1'b0; rmode = 2'b00;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL latency_accept: in_ready %b required 1", in_ready); end
    sb_q.push_back({32'h3FC00000, 4'b0000});
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL latency_1cyc: out_valid %b required 0", out_valid); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL latency_2cyc: out_valid %b required 1", out_valid); end
    if (out_valid && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++; if (out_result !== e[35:4]) begin errors++; $display("FAIL latency_result: got %h required %h", out_result, e[35:4]); end
      checks++; if (out_flags !== e[3:0]) begin errors++; $display("FAIL latency_flags: got %b required %b", out_flags, e[3:0]); end
    end
    @(posedge clk); #1;
    sb_q.delete();
  endtask

  task automatic test_back_to_back();
    beat_t t[24];
    int n = 24;
    int got = 0, cyc = 0, first = 0, last = 0;
    logic [35:0] e;
    t[0]  = mk(0, 10'd127, 23'h7FFFFF, 3'b100, 0, 0, 2'b00, 32'h40000000, 4'b0010);
    t[1]  = mk(0, 10'd127, 23'h7FFFFF, 3'b100, 0, 0, 2'b01, 32'h3FFFFFFF, 4'b0010);
    t[2]  = mk(1, 10'd255, 23'h0,      3'b000, 0, 0, 2'b00, 32'hFF800000, 4'b1010);
    t[3]  = mk(1, 10'd255, 23'h0,      3'b000, 0, 0, 2'b01, 32'hFF7FFFFF, 4'b1010);
    t[4]  = mk(1, 10'd255, 23'h0,      3'b000, 0, 0, 2'b11, 32'hFF7FFFFF, 4'b1010);
    t[5]  = mk(1, 10'd255, 23'h0,      3'b000, 0, 0, 2'b10, 32'hFF800000, 4'b1010);
    t[6]  = mk(0, 10'd255, 23'h0,      3'b000, 0, 0, 2'b10, 32'h7F7FFFFF, 4'b1010);
    t[7]  = mk(1, 10'd0,   23'h0,      3'b000, 0, 0, 2'b00, 32'h80000000, 4'b0110);
    t[8]  = mk(1, 10'd0,   23'h0,      3'b000, 1, 0, 2'b00, 32'h7FC00000, 4'b0001);
    t[9]  = mk(1, 10'd127, 23'h0,      3'b000, 1, 1, 2'b00, 32'h7FC00000, 4'b0001);
    t[10] = mk(1, 10'd127, 23'h0,      3'b000, 0, 1, 2'b00, 32'hFF800000, 4'b0000);
    t[11] = mk(1, 10'd5,   23'h0,      3'b000, 0, 0, 2'b00, 32'h80000000, 4'b0000);
    t[11].mant = '0;
    t[12] = mk(0, 10'd127, 23'h0,      3'b100, 0, 0, 2'b00, 32'h3F800000, 4'b0010);
    t[13] = mk(0, 10'd127, 23'h1,      3'b100, 0, 0, 2'b00, 32'h3F800002, 4'b0010);
    t[14] = mk(1, 10'd127, 23'h0,      3'b001, 0, 0, 2'b10, 32'hBF800001, 4'b0010);
    t[15] = mk(1, 10'd127, 23'h0,      3'b001, 0, 0, 2'b11, 32'hBF800000, 4'b0010);
    t[16] = mk(0, 10'd127, 23'h0,      3'b010, 0, 0, 2'b11, 32'h3F800001, 4'b0010);
    t[17] = mk(0, 10'd254, 23'h7FFFFF, 3'b100, 0, 0, 2'b00, 32'h7F800000, 4'b1010);
    t[18] = mk(0, 10'd254, 23'h7FFFFF, 3'b100, 0, 0, 2'b01, 32'h7F7FFFFF, 4'b0010);
    t[19] = mk(0, 10'h3FD, 23'h0,      3'b000, 0, 0, 2'b00, 32'h00000000, 4'b0110);
    t[20] = mk(0, 10'h1FF, 23'h7FFFFF, 3'b100, 0, 0, 2'b00, 32'h7F800000, 4'b1010);
    t[21] = mk(0, 10'd1,   23'h0,      3'b000, 0, 0, 2'b00, 32'h00800000, 4'b0000);
    t[22] = mk(0, 10'd0,   23'h7FFFFF, 3'b100, 0, 0, 2'b00, 32'h00800000, 4'b0010);
    t[23] = mk(0, 10'd127, 23'h0,      3'b110, 0, 0, 2'b00, 32'h3F800001, 4'b0010);
    @(posedge clk); #1; out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < n; i++) send(t[i]);
        in_valid = 1'b0;
      end
      begin
        while (got < n && cyc < n + 40) begin
          @(negedge clk); cyc++;
          if (out_valid) begin
            if (sb_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL b2b_unexpected: output %h with empty scoreboard", out_result);
            end else begin
              e = sb_q.pop_front();
              checks++; if (out_result !== e[35:4]) begin errors++; $display("FAIL b2b_result[%0d]: got %h required %h", got, out_result, e[35:4]); end
              checks++; if (out_flags !== e[3:0]) begin errors++; $display("FAIL b2b_flags[%0d]: got %b required %b", got, out_flags, e[3:0]); end
            end
            if (got == 0) first = cyc;
            last = cyc;
            got++;
          end
        end
      end
    join
    checks++; if (got !== n) begin errors++; $display("FAIL b2b_count: got %0d beats required %0d", got, n); end
    checks++; if (last - first !== n - 1) begin errors++; $display("FAIL b2b_throughput: span %0d cycles required %0d", last - first, n - 1); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    beat_t bp[4];
    logic [31:0] held_res;
    logic [3:0]  held_flg;
    bit seen = 0;
    int got = 0, budget = 0;
    logic [35:0] e;
    for (int i = 0; i < 4; i++)
      bp[i] = mk(0, 10'd127, 23'(i + 1), 3'b000, 0, 0, 2'b00, 32'h3F800000 + 32'(i + 1), 4'b0000);
    @(posedge clk); #1; out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) send(bp[i]);
        in_valid = 1'b0;
      end
      begin
        repeat (4) begin
          @(negedge clk);
          if (out_valid) begin
            if (!seen) begin
              held_res = out_result; held_flg = out_flags; seen = 1;
              checks++; if (held_res !== 32'h3F800001) begin errors++; $display("FAIL bp_head: got %h required 3f800001", held_res); end
            end else begin
              checks++;
              if (out_result !== held_res || out_flags !== held_flg) begin
                errors++; $display("FAIL bp_stable: got %h/%b required %h/%b", out_result, out_flags, held_res, held_flg);
              end
            end
          end
        end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b required 0", in_ready); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid: got %b required 1", out_valid); end
        checks++; if (sb_q.size() !== 2) begin errors++; $display("FAIL bp_held: %0d beats accepted, required 2", sb_q.size()); end
        @(posedge clk); #1; out_ready = 1'b1;
        while (got < 4 && budget < 40) begin
          @(negedge clk); budget++;
          if (out_valid && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++; if (out_result !== e[35:4]) begin errors++; $display("FAIL bp_result[%0d]: got %h required %h", got, out_result, e[35:4]); end
            checks++; if (out_flags !== e[3:0]) begin errors++; $display("FAIL bp_flags[%0d]: got %b required %b", got, out_flags, e[3:0]); end
            got++;
          end
        end
        checks++; if (got !== 4) begin errors++; $display("FAIL bp_count: got %0d beats required 4", got); end
      end
    join
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int leaks = 0, budget = 0;
    bit got = 0;
    logic [35:0] e;
    @(posedge clk); #1; out_ready = 1'b0;
    send(mk(0, 10'd130, 23'h123456, 3'b000, 0, 0, 2'b00, 32'h41123456, 4'b0000));
    send(mk(1, 10'd130, 23'h654321, 3'b000, 0, 0, 2'b00, 32'hC1654321, 4'b0000));
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL rmid_full: out_valid %b in_ready %b required 1 0", out_valid, in_ready); end
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL rmid_during: out_valid %b in_ready %b required 0 0", out_valid, in_ready); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b required 0", out_valid); end
    checks++; if (out_result !== 32'h0) begin errors++; $display("FAIL rmid_result: got %h required 00000000", out_result); end
    checks++; if (out_flags !== 4'h0) begin errors++; $display("FAIL rmid_flags: got %b required 0000", out_flags); end
    @(posedge clk); #1; rst = 1'b0; out_ready = 1'b1; sb_q.delete();
    repeat (6) begin
      @(negedge clk);
      if (out_valid) leaks++;
    end
    checks++; if (leaks !== 0) begin errors++; $display("FAIL rmid_leak: %0d stale beats appeared, required 0", leaks); end
    @(posedge clk); #1;
    send(mk(0, 10'd126, 23'h0, 3'b011, 0, 0, 2'b01, 32'h3F000000, 4'b0010));
    in_valid = 1'b0;
    while (!got && budget < 20) begin
      @(negedge clk); budget++;
      if (out_valid && sb_q.size() > 0) begin
        e = sb_q.pop_front(); got = 1;
        checks++; if (out_result !== e[35:4] || out_flags !== e[3:0]) begin
          errors++; $display("FAIL rmid_restart: got %h/%b required %h/%b", out_result, out_flags, e[35:4], e[3:0]);
        end
      end
    end
    checks++; if (!got) begin errors++; $display("FAIL rmid_restart_timeout: no output within %0d cycles", budget); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
